fir_lparallel: RTL and testbench

FIR_LPARALLEL -- requirements
Module: fir_lparallel

---
 rtl/fir_lparallel.sv | 133 +++++++++++++
 tb/tb_fir_lparallel.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fir_lparallel.sv
// fir_lparallel: block-parallel direct-form FIR, LANES samples per cycle.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_data     one block of LANES signed samples; lane j = x[LANES*m+j]
//   clear                 flush sample history (coefficients kept)
//   coef_we/addr/data     write h[coef_addr]; addresses >= TAPS are ignored
//   out_valid, out_data   one result block per accepted block, 2 edges later
//
// Pipeline: edge t registers all tap products (coefficients and history are
// sampled here, so later coefficient writes or clears cannot disturb the
// block), edge t+1 registers the per-lane sums, edge t+2 loads out_data.

module fir_lane #(
  parameter int TAPS   = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 36
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [TAPS-1:0][DATA_W-1:0]    win,   // win[k] = x[n-k]
  input  logic [TAPS-1:0][COEF_W-1:0]    coef,
  output logic [ACC_W-1:0]               sum
);
  logic [TAPS-1:0][ACC_W-1:0] prod_d, prod_q;
  logic [ACC_W-1:0]           acc;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic signed [ACC_W-1:0] ce, xe;
    assign ce        = {{(ACC_W-COEF_W){coef[k][COEF_W-1]}}, coef[k]};
    assign xe        = {{(ACC_W-DATA_W){win[k][DATA_W-1]}}, win[k]};
    assign prod_d[k] = ce * xe;
  end

  // Two's-complement sum at ACC_W bits is exact for the legal parameter range.
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + prod_q[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      sum    <= '0;
    end else begin
      prod_q <= prod_d;
      sum    <= acc;
    end
  end
endmodule

module fir_lparallel #(
  parameter int LANES  = 2,
  parameter int TAPS   = 16,
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      clear,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]         coef_data,
  output logic                      out_valid,
  output logic [LANES*ACC_W-1:0]    out_data
);
  localparam int HN = TAPS - 1;          // history depth
  localparam int EN = LANES + TAPS - 1;  // current block + history

  logic [TAPS-1:0][COEF_W-1:0]           coef;
  logic [HN-1:0][DATA_W-1:0]             hist;   // hist[0] = newest past sample
  logic [EN-1:0][DATA_W-1:0]             ext;    // ext[0] = newest sample overall
  logic [LANES-1:0][TAPS-1:0][DATA_W-1:0] win;
  logic [LANES-1:0][ACC_W-1:0]           lane_sum;
  logic [3:1]                            vld_pipe;

  // Newest-first sample line; a clear on this edge makes history read as zero.
  for (genvar i = 0; i < EN; i++) begin : g_ext
    if (i < LANES) begin : g_cur
      assign ext[i] = in_data[(LANES-1-i)*DATA_W +: DATA_W];
    end else begin : g_old
      assign ext[i] = clear ? '0 : hist[i-LANES];
    end
  end

  // Lane j sees x[n-k] at ext[LANES-1-j+k].
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    for (genvar k = 0; k < TAPS; k++) begin : g_win
      assign win[j][k] = ext[LANES-1-j+k];
    end
    fir_lane #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .win  (win[j]),
      .coef (coef),
      .sum  (lane_sum[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
    end else if (in_valid) begin
      hist <= ext[HN-1:0];
    end else if (clear) begin
      hist <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= (k == 0) ? COEF_W'(1) : '0;
    end else if (coef_we && (int'(coef_addr) < TAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      out_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[2:1], in_valid};
      if (vld_pipe[2]) out_data <= lane_sum;
    end
  end

  assign out_valid = vld_pipe[3];
endmodule

// File: tb/tb_fir_lparallel.sv
// Directed bench for fir_lparallel at default parameters (LANES=2, TAPS=16).
// Inputs are driven and outputs sampled on the falling edge; a block driven
// in tick i appears in the sample taken at tick i+3.
module tb_fir_lparallel;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clear;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_data;
  logic        out_valid;
  logic [71:0] out_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic               ov;
  logic signed [35:0] o0, o1;

  localparam longint P30 = 64'sd1073741824;
  localparam longint P34 = 64'sd17179869184;

  fir_lparallel dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clear    (clear),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Sample outputs at the falling edge, then drive the next cycle's inputs.
  task automatic tick(input logic v, input int a, input int b, input logic clr,
                      input logic we, input int addr, input int cd);
    @(negedge clk);
    ov = out_valid;
    o0 = out_data[35:0];
    o1 = out_data[71:36];
    in_valid  = v;
    in_data   = {16'(b), 16'(a)};
    clear     = clr;
    coef_we   = we;
    coef_addr = 4'(addr);
    coef_data = 16'(cd);
  endtask

  task automatic blk(input int a, input int b, input logic clr);
    tick(1'b1, a, b, clr, 1'b0, 0, 0);
  endtask
  task automatic idle();
    tick(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
  endtask
  task automatic wr(input int addr, input int cd);
    tick(1'b0, 0, 0, 1'b0, 1'b1, addr, cd);
  endtask

  task automatic chk_out(input string tag, input longint e0, input longint e1);
    chk({tag, ".v"}, longint'(ov), 1);
    chk({tag, ".y0"}, o0, e0);
    chk({tag, ".y1"}, o1, e1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    #12;
    chk("rst.valid", longint'(out_valid), 0);
    chk("rst.data", longint'(out_data != 72'd0), 0);
    @(negedge clk); rst_n = 1'b1;

    // Identity filter out of reset, back-to-back blocks.
    blk(5, -7, 1'b0);
    blk(100, 3, 1'b0);
    idle();
    chk("id.lat1", longint'(ov), 0);
    idle(); chk_out("id.b0", 5, -7);
    idle(); chk_out("id.b1", 100, 3);
    idle();
    chk("id.idle_v", longint'(ov), 0);
    chk("id.hold", o0, 100);

    // Impulse with h = [1,2,3,0...].
    wr(1, 2); wr(2, 3);
    blk(1, 0, 1'b1); blk(0, 0, 1'b0); blk(0, 0, 1'b0);
    idle(); chk_out("imp.b0", 1, 2);
    idle(); chk_out("imp.b1", 3, 0);
    idle(); chk_out("imp.b2", 0, 0);
    idle(); chk("imp.end_v", longint'(ov), 0);

    // Idle gaps neither shift history nor produce results.
    blk(1, 0, 1'b1); idle(); idle();
    blk(0, 0, 1'b0); chk_out("gap.b0", 1, 2);
    idle(); chk("gap.idle1", longint'(ov), 0);
    idle(); chk("gap.idle2", longint'(ov), 0);
    idle(); chk_out("gap.b1", 3, 0);
    idle(); chk("gap.end_v", longint'(ov), 0);

    // Coefficient write on the same edge as a block uses the old value.
    wr(1, 0); wr(2, 0);
    tick(1'b1, 4, 4, 1'b1, 1'b1, 0, 2);
    blk(4, 4, 1'b0);
    idle(); idle(); chk_out("same.b0", 4, 4);
    idle(); chk_out("same.b1", 8, 8);

    // Extremes: all taps and samples at -32768.
    for (int k = 0; k < 16; k++) wr(k, -32768);
    blk(-32768, -32768, 1'b1);
    for (int m = 1; m < 9; m++) blk(-32768, -32768, 1'b0);
    idle(); idle(); chk_out("ext.b7", 15 * P30, P34);
    idle(); chk_out("ext.b8", P34, P34);

    // Reset with two blocks in flight.
    blk(1, 1, 1'b0); blk(2, 2, 1'b0); idle();
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", longint'(out_valid), 0);
    chk("mrst.data", longint'(out_data != 72'd0), 0);
    idle(); chk("mrst.v1", longint'(ov), 0);
    idle(); chk("mrst.v2", longint'(ov), 0);
    rst_n = 1'b1;
    idle(); chk("mrst.v3", longint'(ov), 0);
    idle(); chk("mrst.v4", longint'(ov), 0);
    idle(); chk("mrst.v5", longint'(ov), 0);
    wr(1, 2); wr(2, 3);
    blk(1, 0, 1'b0); idle(); idle();
    idle(); chk_out("mrst.imp", 1, 2);

    // Clear mid-stream: in-flight results survive, cleared block sees zeros.
    blk(5, 6, 1'b0); blk(7, 8, 1'b0); blk(1, 0, 1'b1);
    idle(); chk_out("clr.b0", 8, 16);
    idle(); chk_out("clr.b1", 34, 40);
    idle(); chk_out("clr.b2", 1, 2);
    idle(); chk("clr.end_v", longint'(ov), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
